quire_generic: RTL and testbench

Parametrised posit quire accumulator, the general-width successor of the fixed 4-bit/es=0 quire. It accepts decoded posit values (sign, scale, fraction, zero, NaR) framed by sow/eow, and aligns each value into a two's-complement fixed-point quire. It accumulates exactly over a window and emits the quire to the downstream rounding/encode stage. New over the previous generation: arbitrary POSIT_WIDTH/ES, windowed restart on sow, sticky NaR and overflow per window, and an eow-only output mode.

---
 rtl/quire_generic.sv | 132 +++++++++++++
 tb/tb_quire_generic.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quire_generic.sv
// Posit quire accumulator: aligns decoded posit values into a two's-complement
// fixed-point quire and sums them exactly over sow/eow-framed windows.
module quire_generic #(
  parameter int POSIT_WIDTH  = 8,
  parameter int ES           = 0,
  parameter int LOG_NB_ACCUM = 10,
  parameter int OUTPUT_ALL   = 1,
  localparam int FW    = POSIT_WIDTH - ES - 3,
  localparam int SW    = ES + $clog2(POSIT_WIDTH) + 2,
  localparam int NQMIN = (2 ** (ES + 2)) * (POSIT_WIDTH - 2) + 1,
  localparam int BP    = (2 ** (ES + 1)) * (POSIT_WIDTH - 2),
  localparam int NQ    = NQMIN + LOG_NB_ACCUM
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rts_i,
  output logic          rtr_o,
  input  logic          sow_i,
  input  logic          eow_i,
  input  logic [FW-1:0] fraction_i,
  input  logic [SW-1:0] scale_i,
  input  logic          sign_i,
  input  logic          zero_i,
  input  logic          NaR_i,
  input  logic          rtr_i,
  output logic          rts_o,
  output logic          sow_o,
  output logic          eow_o,
  output logic [NQ-1:0] data_o,
  output logic          sign_o,
  output logic          zero_o,
  output logic          NaR_o,
  output logic          ovf_o
);

  // Place {1,fraction} so that quire bit BP carries weight 2^0.
  function automatic logic [NQ-1:0] f_align(input logic [FW-1:0] frac,
                                            input logic [SW-1:0] scale);
    logic signed [31:0] sh;
    logic        [31:0] amt;
    logic      [NQ-1:0] mag;
    mag = {{(NQ-FW-1){1'b0}}, 1'b1, frac};
    sh  = BP - FW + 32'(signed'(scale));
    amt = (sh >= 0) ? sh : -sh;
    if (sh >= 0) f_align = mag << amt;
    else         f_align = mag >> amt;
  endfunction

  function automatic logic f_ovf(input logic signed [NQ-1:0] a,
                                 input logic signed [NQ-1:0] b,
                                 input logic signed [NQ-1:0] s);
    f_ovf = (a[NQ-1] == b[NQ-1]) && (s[NQ-1] != a[NQ-1]);
  endfunction

  logic                 w_proc_en;
  logic                 w_accept;
  logic                 r_vld_p1;
  logic [NQ-1:0]        r_mag_p1;
  logic                 r_sign_p1;
  logic                 r_zero_p1;
  logic                 r_nar_p1;
  logic                 r_sow_p1;
  logic                 r_eow_p1;
  logic signed [NQ-1:0] w_term;
  logic signed [NQ-1:0] w_sum;
  logic                 r_vld_p2;
  logic                 r_sow_p2;
  logic                 r_eow_p2;
  logic signed [NQ-1:0] r_quire_p2;
  logic                 r_nar_p2;
  logic                 r_ovf_p2;

  assign w_proc_en = rtr_i | ~r_vld_p2;
  assign w_accept  = rts_i & w_proc_en;
  assign rtr_o     = w_proc_en;

  // Stage 1: alignment into the quire grid
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mag_p1  <= f_align(fraction_i, scale_i);
      r_sign_p1 <= sign_i;
      r_zero_p1 <= zero_i;
      r_nar_p1  <= NaR_i;
      r_sow_p1  <= sow_i;
      r_eow_p1  <= eow_i;
    end
  end

  // NaR and zero beats contribute nothing to the sum.
  assign w_term = (r_zero_p1 | r_nar_p1) ? '0 :
                  (r_sign_p1 ? -$signed(r_mag_p1) : $signed(r_mag_p1));
  assign w_sum  = r_quire_p2 + w_term;

  // Stage 2: accumulation and windowing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_sow_p2   <= 1'b0;
      r_eow_p2   <= 1'b0;
      r_quire_p2 <= '0;
      r_nar_p2   <= 1'b0;
      r_ovf_p2   <= 1'b0;
    end else if (w_proc_en) begin
      r_vld_p1 <= rts_i;
      r_vld_p2 <= r_vld_p1 & ((OUTPUT_ALL != 0) | r_eow_p1);
      if (r_vld_p1) begin
        r_sow_p2 <= r_sow_p1;
        r_eow_p2 <= r_eow_p1;
        if (r_sow_p1) begin
          r_quire_p2 <= w_term;
          r_nar_p2   <= r_nar_p1;
          r_ovf_p2   <= 1'b0;
        end else begin
          r_quire_p2 <= w_sum;
          r_nar_p2   <= r_nar_p2 | r_nar_p1;
          r_ovf_p2   <= r_ovf_p2 | f_ovf(r_quire_p2, w_term, w_sum);
        end
      end
    end
  end

  assign rts_o  = r_vld_p2;
  assign sow_o  = r_sow_p2;
  assign eow_o  = r_eow_p2;
  assign data_o = r_quire_p2;
  assign sign_o = r_quire_p2[NQ-1];
  assign zero_o = (r_quire_p2 == '0);
  assign NaR_o  = r_nar_p2;
  assign ovf_o  = r_ovf_p2;

endmodule

// File: tb/tb_quire_generic.sv
// Directed scoreboard bench for quire_generic (N=8, ES=0, LOG_NB_ACCUM=4),
// with one instance per output mode sharing the same stimulus.
module tb_quire_generic;
  localparam int NQ = 29;

  logic clk = 1'b0;
  logic rst_n;
  logic rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0;
  logic sign_i = 1'b0, zero_i = 1'b0, nar_i = 1'b0, rtr_i = 1'b1;
  logic [4:0] frac_i = '0;
  logic [4:0] scale_i = '0;
  logic rts_i_b;
  logic rtr_i_b = 1'b1;

  logic rtr_o_a, rts_o_a, sow_o_a, eow_o_a, sign_o_a, zero_o_a, nar_o_a, ovf_o_a;
  logic rtr_o_b, rts_o_b, sow_o_b, eow_o_b, sign_o_b, zero_o_b, nar_o_b, ovf_o_b;
  logic [NQ-1:0] data_o_a, data_o_b;

  assign rts_i_b = rts_i & rtr_o_a;

  always #5 clk = ~clk;

  quire_generic #(.POSIT_WIDTH(8), .ES(0), .LOG_NB_ACCUM(4), .OUTPUT_ALL(1)) u_all (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o_a), .sow_i(sow_i), .eow_i(eow_i),
    .fraction_i(frac_i), .scale_i(scale_i), .sign_i(sign_i), .zero_i(zero_i), .NaR_i(nar_i),
    .rtr_i(rtr_i), .rts_o(rts_o_a), .sow_o(sow_o_a), .eow_o(eow_o_a), .data_o(data_o_a),
    .sign_o(sign_o_a), .zero_o(zero_o_a), .NaR_o(nar_o_a), .ovf_o(ovf_o_a));

  quire_generic #(.POSIT_WIDTH(8), .ES(0), .LOG_NB_ACCUM(4), .OUTPUT_ALL(0)) u_eow (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i_b), .rtr_o(rtr_o_b), .sow_i(sow_i), .eow_i(eow_i),
    .fraction_i(frac_i), .scale_i(scale_i), .sign_i(sign_i), .zero_i(zero_i), .NaR_i(nar_i),
    .rtr_i(rtr_i_b), .rts_o(rts_o_b), .sow_o(sow_o_b), .eow_o(eow_o_b), .data_o(data_o_b),
    .sign_o(sign_o_b), .zero_o(zero_o_b), .NaR_o(nar_o_b), .ovf_o(ovf_o_b));

  typedef struct packed {
    logic [NQ-1:0] data;
    logic sow, eow, nar, ovf;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int total = 0;
  int bad = 0;
  int nb_b = 0;
  longint m_q = 0;
  bit m_nar = 0, m_ovf = 0;
  logic [NQ-1:0] last_a = '0, last_b = '0;
  logic last_a_ovf = 0, last_a_nar = 0, last_a_sign = 0, last_a_zero = 0;
  logic last_b_sow = 0, last_b_eow = 0, last_b_nar = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value (1+f/32)*2^scale scaled by 2^12, accumulated as a wide integer.
  task automatic push(input bit sow, input bit eow, input logic [4:0] frac,
                      input logic [4:0] sc, input bit sg, input bit z, input bit n);
    longint t, s;
    int sh;
    exp_t e;
    sh = 7 + int'($signed(sc));
    if (z || n) t = 0;
    else if (sh >= 0) t = longint'(32 + int'(frac)) << sh;
    else t = longint'(32 + int'(frac)) >> (-sh);
    if (sg) t = -t;
    if (sow) begin
      s = t; m_ovf = 0; m_nar = n;
    end else begin
      s = m_q + t; m_nar = m_nar | n;
      if (s > (longint'(1) << 28) - 1 || s < -(longint'(1) << 28)) m_ovf = 1;
    end
    s = s & ((longint'(1) << 29) - 1);
    if (s >= (longint'(1) << 28)) s = s - (longint'(1) << 29);
    m_q = s;
    e.data = s[NQ-1:0]; e.sow = sow; e.eow = eow; e.nar = m_nar; e.ovf = m_ovf;
    sb_a.push_back(e);
    if (eow) sb_b.push_back(e);
  endtask

  task automatic send(input bit sow, input bit eow, input logic [4:0] frac,
                      input logic [4:0] sc, input bit sg, input bit z, input bit n);
    int k;
    bit acc;
    sow_i = sow; eow_i = eow; frac_i = frac; scale_i = sc;
    sign_i = sg; zero_i = z; nar_i = n; rts_i = 1'b1;
    k = 0; acc = 0;
    while (!acc && k < 100) begin
      @(negedge clk); acc = rtr_o_a;
      @(posedge clk); #1; k++;
    end
    rts_i = 1'b0;
    chk("send_accept", 64'(acc), 64'(1));
    if (acc) push(sow, eow, frac, sc, sg, z, n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && k < 200) begin
      @(posedge clk); k++;
    end
    #1;
    chk("drain_a", 64'(sb_a.size()), 64'(0));
    chk("drain_b", 64'(sb_b.size()), 64'(0));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rts"},  64'(rts_o_a),  64'(0));
    chk({tag, "_data"}, 64'(data_o_a), 64'(0));
    chk({tag, "_zero"}, 64'(zero_o_a), 64'(1));
    chk({tag, "_sign"}, 64'(sign_o_a), 64'(0));
    chk({tag, "_nar"},  64'(nar_o_a),  64'(0));
    chk({tag, "_ovf"},  64'(ovf_o_a),  64'(0));
    chk({tag, "_sow"},  64'(sow_o_a),  64'(0));
    chk({tag, "_eow"},  64'(eow_o_a),  64'(0));
    chk({tag, "_rtr"},  64'(rtr_o_a),  64'(1));
    chk({tag, "_rtsb"}, 64'(rts_o_b),  64'(0));
  endtask

  // Output monitors: pop the scoreboard whenever a beat is handed downstream.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && rts_o_a && rtr_i) begin
      chk("a_q_nonempty", 64'(sb_a.size() != 0), 64'(1));
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("a_data", 64'(data_o_a), 64'(e.data));
        chk("a_sign", 64'(sign_o_a), 64'(e.data[NQ-1]));
        chk("a_zero", 64'(zero_o_a), 64'(e.data == '0));
        chk("a_sow",  64'(sow_o_a),  64'(e.sow));
        chk("a_eow",  64'(eow_o_a),  64'(e.eow));
        chk("a_nar",  64'(nar_o_a),  64'(e.nar));
        chk("a_ovf",  64'(ovf_o_a),  64'(e.ovf));
      end
      last_a = data_o_a; last_a_ovf = ovf_o_a; last_a_nar = nar_o_a;
      last_a_sign = sign_o_a; last_a_zero = zero_o_a;
    end
    if (rst_n === 1'b1 && rts_o_b) begin
      chk("b_q_nonempty", 64'(sb_b.size() != 0), 64'(1));
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("b_data", 64'(data_o_b), 64'(e.data));
        chk("b_sow",  64'(sow_o_b),  64'(e.sow));
        chk("b_eow",  64'(eow_o_b),  64'(e.eow));
        chk("b_nar",  64'(nar_o_b),  64'(e.nar));
        chk("b_ovf",  64'(ovf_o_b),  64'(e.ovf));
      end
      nb_b++;
      last_b = data_o_b; last_b_sow = sow_o_b; last_b_eow = eow_o_b; last_b_nar = nar_o_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // three-beat window: +1.0, +1.5, -1.0
    nb0 = nb_b;
    send(1, 0, 5'd0, 5'd0, 0, 0, 0);
    send(0, 0, 5'b10000, 5'd0, 0, 0, 0);
    send(0, 1, 5'd0, 5'd0, 1, 0, 0);
    drain();
    chk("win_a_last", 64'(last_a), 64'(6144));
    chk("win_b_cnt", 64'(nb_b - nb0), 64'(1));
    chk("win_b_data", 64'(last_b), 64'(6144));
    chk("win_b_sow", 64'(last_b_sow), 64'(0));
    chk("win_b_eow", 64'(last_b_eow), 64'(1));

    // minpos and -minpos as one-term windows
    send(1, 1, 5'd0, 5'b10100, 0, 0, 0);
    drain();
    chk("minpos", 64'(last_a), 64'(1));
    send(1, 1, 5'd0, 5'b10100, 1, 0, 0);
    drain();
    chk("neg_minpos", 64'(last_a), 64'(29'h1FFF_FFFF));
    chk("neg_minpos_sign", 64'(last_a_sign), 64'(1));

    // maxpos accumulation up to overflow
    for (int i = 0; i < 15; i++) send(i == 0, 0, 5'd0, 5'd12, 0, 0, 0);
    drain();
    chk("maxpos15", 64'(last_a), 64'(15) << 24);
    chk("maxpos15_ovf", 64'(last_a_ovf), 64'(0));
    send(0, 1, 5'd0, 5'd12, 0, 0, 0);
    drain();
    chk("maxpos16_ovf", 64'(last_a_ovf), 64'(1));
    send(1, 1, 5'd0, 5'd0, 0, 0, 0);
    drain();
    chk("ovf_clear", 64'(last_a_ovf), 64'(0));

    // NaR in the middle of a window
    send(1, 0, 5'd0, 5'd0, 0, 0, 0);
    send(0, 0, 5'd0, 5'd0, 0, 0, 1);
    send(0, 0, 5'b10000, 5'd0, 0, 0, 0);
    send(0, 1, 5'd0, 5'd0, 1, 0, 0);
    drain();
    chk("nar_sum", 64'(last_a), 64'(6144));
    chk("nar_sticky", 64'(last_a_nar), 64'(1));
    chk("nar_b", 64'(last_b_nar), 64'(1));

    // zero beat with garbage fields, then a window summing to zero
    send(1, 0, 5'd0, 5'd0, 0, 0, 0);
    send(0, 0, 5'd31, 5'd7, 1, 1, 0);
    drain();
    chk("zero_beat", 64'(last_a), 64'(4096));
    chk("nar_cleared", 64'(last_a_nar), 64'(0));
    send(0, 1, 5'd0, 5'd0, 1, 0, 0);
    drain();
    chk("sum_zero", 64'(last_a_zero), 64'(1));

    // backpressure while upstream keeps sending
    fork
      begin
        rtr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_rtr", 64'(rtr_o_a), 64'(0));
        chk("bp_hold_val", 64'(data_o_a), 64'(4096));
        chk("bp_q", 64'(sb_a.size() != 0), 64'(1));
        if (sb_a.size() != 0) chk("bp_hold1", 64'(data_o_a), 64'(sb_a[0].data));
        repeat (2) @(posedge clk);
        #1;
        chk("bp_rts", 64'(rts_o_a), 64'(1));
        chk("bp_hold2", 64'(data_o_a), 64'(4096));
        rtr_i = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) send(i == 0, i == 5, 5'd0, 5'd0, 0, 0, 0);
      end
    join
    drain();
    chk("bp_sum", 64'(last_a), 64'(24576));

    // asynchronous reset mid-window
    send(1, 0, 5'd0, 5'd0, 0, 0, 0);
    send(0, 0, 5'd0, 5'd0, 0, 0, 0);
    rst_n = 1'b0;
    sb_a.delete(); sb_b.delete();
    m_q = 0; m_nar = 0; m_ovf = 0;
    #1;
    chk_reset_vals("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 0, 5'b10000, 5'd0, 0, 0, 0);
    send(0, 1, 5'd0, 5'd0, 0, 0, 0);
    drain();
    chk("post_rst_sum", 64'(last_a), 64'(10240));
    chk("post_rst_b", 64'(last_b), 64'(10240));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
